// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_pkg
//  Description : Shared state codes, LFSR constants and the millisecond
//                divider helper for the multi-player reaction timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    // State codes driven on the state output
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_COUNTDOWN = 3'd2;
    localparam logic [2:0] S_TEST      = 3'd3;
    localparam logic [2:0] S_EARLY     = 3'd4;
    localparam logic [2:0] S_GOOD      = 3'd5;
    localparam logic [2:0] S_LATE      = 3'd6;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] C_LFSR_POLY = 16'hB400;
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

    // Clock cycles per millisecond
    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : N-bit two-flop synchronizer followed by a rising-edge
//                detector. o_edge is high for one cycle per press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_edge
);

    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;
    logic [N-1:0] r_prev;

    // Two-stage synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_mp
//  Description : Multi-player reaction timer core: prompt, random wait,
//                LED stimulus, millisecond measurement of the fastest stop
//                button, per-player best times and early/good/late result.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PLAYERS      = 2,
    parameter int TIME_W       = 14,
    parameter int INIT_MS      = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int SPAN_LOG2    = 11,
    parameter int LATE_MS      = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_b,
    input  logic                      clear_b,
    input  logic [PLAYERS-1:0]        stop_b,
    output logic                      led,
    output logic [2:0]                state,
    output logic [2:0]                winner,
    output logic [TIME_W-1:0]         reaction_ms,
    output logic [PLAYERS*TIME_W-1:0] best_ms,
    output logic                      new_best
);

    localparam int DIV       = ms_div(CLK_HZ);
    localparam int PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_DELAY = MIN_DELAY_MS + (1 << SPAN_LOG2) - 1;
    localparam int CNT_MAX   = (INIT_MS > MAX_DELAY) ? INIT_MS : MAX_DELAY;
    localparam int DW        = $clog2(CNT_MAX + 1);

    logic [2:0]        r_state;
    logic              r_led;
    logic [2:0]        r_winner;
    logic [TIME_W-1:0] r_ms;
    logic              r_new_best;
    logic [TIME_W-1:0] r_best [PLAYERS];
    logic [PW-1:0]     r_presc;
    logic [DW-1:0]     r_cnt;
    logic [15:0]       r_lfsr;

    logic [1:0]         w_ctl_edge;
    logic [PLAYERS-1:0] w_stop_edge;
    logic               w_start;
    logic               w_clear;
    logic               w_stop_any;
    logic               w_tick;
    logic [2:0]         w_stop_idx;
    logic [TIME_W-1:0]  w_ms_inc;
    logic [DW-1:0]      w_rand;
    logic [DW-1:0]      w_delay_load;

    // Lowest-numbered player wins a tie between simultaneous presses
    function automatic logic [2:0] lowest_idx(input logic [PLAYERS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    btn_sync_edge #(.N(2)) u_sync_ctl (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  ({clear_b, start_b}),
        .o_edge (w_ctl_edge)
    );

    btn_sync_edge #(.N(PLAYERS)) u_sync_stop (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (stop_b),
        .o_edge (w_stop_edge)
    );

    assign w_start    = w_ctl_edge[0];
    assign w_clear    = w_ctl_edge[1];
    assign w_stop_any = |w_stop_edge;
    assign w_stop_idx = lowest_idx(w_stop_edge);
    assign w_tick     = (r_presc == PW'(DIV - 1));
    assign w_ms_inc   = r_ms + TIME_W'(1);

    generate
        if (SPAN_LOG2 > 0) begin : g_rand_span
            assign w_rand = DW'(r_lfsr[SPAN_LOG2-1:0]);
        end else begin : g_rand_fixed
            assign w_rand = '0;
        end
    endgenerate

    assign w_delay_load = DW'(MIN_DELAY_MS) + w_rand;

    // Free-running pseudo-random source, one step per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= C_LFSR_SEED;
        else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? C_LFSR_POLY : 16'h0000);
    end

    // Round FSM with prescaler, timers and best-time file; clear has top priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_led      <= 1'b0;
            r_winner   <= '0;
            r_ms       <= '0;
            r_new_best <= 1'b0;
            r_presc    <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < PLAYERS; i++) r_best[i] <= '1;
        end else begin
            r_new_best <= 1'b0;
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            if (w_clear) begin
                r_state  <= S_IDLE;
                r_ms     <= '0;
                r_winner <= '0;
                r_led    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_EARLY, S_GOOD, S_LATE: begin
                        if (w_start) begin
                            r_state <= S_INIT;
                            r_cnt   <= DW'(INIT_MS);
                            r_presc <= '0;
                        end
                    end
                    S_INIT: begin
                        if (w_tick) begin
                            if (r_cnt == DW'(1)) begin
                                r_state <= S_COUNTDOWN;
                                r_cnt   <= w_delay_load;
                                r_presc <= '0;
                            end else begin
                                r_cnt <= r_cnt - DW'(1);
                            end
                        end
                    end
                    S_COUNTDOWN: begin
                        if (w_stop_any) begin
                            r_state  <= S_EARLY;
                            r_winner <= w_stop_idx;
                            r_ms     <= '0;
                        end else if (w_tick) begin
                            if (r_cnt == DW'(1)) begin
                                r_state <= S_TEST;
                                r_led   <= 1'b1;
                                r_ms    <= '0;
                                r_presc <= '0;
                            end else begin
                                r_cnt <= r_cnt - DW'(1);
                            end
                        end
                    end
                    S_TEST: begin
                        // A stop on a tick cycle keeps the pre-increment value
                        if (w_stop_any) begin
                            r_state  <= S_GOOD;
                            r_led    <= 1'b0;
                            r_winner <= w_stop_idx;
                            for (int i = 0; i < PLAYERS; i++) begin
                                if ((w_stop_idx == 3'(i)) && (r_ms < r_best[i])) begin
                                    r_best[i]  <= r_ms;
                                    r_new_best <= 1'b1;
                                end
                            end
                        end else if (w_tick) begin
                            if (w_ms_inc == TIME_W'(LATE_MS)) begin
                                r_state  <= S_LATE;
                                r_led    <= 1'b0;
                                r_winner <= '0;
                            end
                            r_ms <= w_ms_inc;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_best_out
            assign best_ms[gi*TIME_W +: TIME_W] = r_best[gi];
        end
    endgenerate

    assign led         = r_led;
    assign state       = r_state;
    assign winner      = r_winner;
    assign reaction_ms = r_ms;
    assign new_best    = r_new_best;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_timer_mp
//  Description : Directed self-checking bench for reaction_timer_mp using a
//                4-clock millisecond so rounds complete in a few hundred clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_mp;

    localparam int TW = 14;
    localparam logic [TW-1:0] C_ALL1 = 14'd16383;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_b = 1'b0;
    logic          clear_b = 1'b0;
    logic [1:0]    stop_b = 2'b00;
    logic          led;
    logic [2:0]    state;
    logic [2:0]    winner;
    logic [TW-1:0] reaction_ms;
    logic [2*TW-1:0] best_ms;
    logic          new_best;

    int checks = 0;
    int errors = 0;
    int nb_cnt = 0;
    bit led_seen = 1'b0;

    reaction_timer_mp #(
        .CLK_HZ       (4000),
        .PLAYERS      (2),
        .TIME_W       (TW),
        .INIT_MS      (2),
        .MIN_DELAY_MS (5),
        .SPAN_LOG2    (0),
        .LATE_MS      (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_b     (start_b),
        .clear_b     (clear_b),
        .stop_b      (stop_b),
        .led         (led),
        .state       (state),
        .winner      (winner),
        .reaction_ms (reaction_ms),
        .best_ms     (best_ms),
        .new_best    (new_best)
    );

    always #5 clk = ~clk;

    // Count new_best pulses and remember whether the LED was ever lit
    always @(negedge clk) begin
        if (new_best === 1'b1) nb_cnt++;
        if (led === 1'b1) led_seen = 1'b1;
    end

    task automatic wait_state(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (state === s) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ms(input logic [TW-1:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (reaction_ms === v) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic press_start();
        @(negedge clk) start_b = 1'b1;
        repeat (4) @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %0b want 0", led); end
        checks++; if (reaction_ms !== 0 || winner !== 0 || new_best !== 1'b0) begin
            errors++; $display("FAIL reset_outs ms %0d win %0d nb %0b want 0 0 0", reaction_ms, winner, new_best); end
        checks++; if (best_ms[TW-1:0] !== C_ALL1) begin errors++; $display("FAIL reset_slot0 got %0d want 16383", best_ms[TW-1:0]); end
        checks++; if (best_ms[2*TW-1:TW] !== C_ALL1) begin errors++; $display("FAIL reset_slot1 got %0d want 16383", best_ms[2*TW-1:TW]); end
    endtask

    // One round where player 1 stops once reaction_ms has reached n
    task automatic run_round_p1(input logic [TW-1:0] n, input logic [TW-1:0] exp_slot1,
                                input int exp_pulses, input string tag);
        bit ok;
        nb_cnt = 0;
        press_start();
        wait_state(3'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_reach_test timeout state %0d want 3", tag, state); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL %s_led_in_test got %0b want 1", tag, led); end
        wait_ms(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_reach_ms timeout ms %0d want %0d", tag, reaction_ms, n); end
        stop_b = 2'b10;
        wait_state(3'd5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_reach_good timeout state %0d want 5", tag, state); end
        repeat (3) @(negedge clk);
        stop_b = 2'b00;
        checks++; if (reaction_ms !== n) begin errors++; $display("FAIL %s_ms got %0d want %0d", tag, reaction_ms, n); end
        checks++; if (winner !== 3'd1) begin errors++; $display("FAIL %s_winner got %0d want 1", tag, winner); end
        checks++; if (best_ms[2*TW-1:TW] !== exp_slot1) begin errors++; $display("FAIL %s_slot1 got %0d want %0d", tag, best_ms[2*TW-1:TW], exp_slot1); end
        checks++; if (nb_cnt !== exp_pulses) begin errors++; $display("FAIL %s_new_best_pulses got %0d want %0d", tag, nb_cnt, exp_pulses); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL %s_led_good got %0b want 0", tag, led); end
    endtask

    task automatic test_good_round();
        run_round_p1(14'd7, 14'd7, 1, "good");
    endtask

    task automatic test_back_to_back();
        run_round_p1(14'd9, 14'd7, 0, "second");
    endtask

    task automatic test_early();
        bit ok;
        led_seen = 1'b0;
        press_start();
        wait_state(3'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL early_reach_cd timeout state %0d want 2", state); end
        stop_b = 2'b01;
        wait_state(3'd4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL early_reach_early timeout state %0d want 4", state); end
        repeat (3) @(negedge clk);
        stop_b = 2'b00;
        checks++; if (reaction_ms !== 0 || winner !== 0) begin errors++; $display("FAIL early_result ms %0d win %0d want 0 0", reaction_ms, winner); end
        checks++; if (led_seen) begin errors++; $display("FAIL early_led_seen got 1 want 0"); end
        checks++; if (best_ms !== {14'd7, C_ALL1}) begin errors++; $display("FAIL early_slots got %0d,%0d want 16383,7", best_ms[TW-1:0], best_ms[2*TW-1:TW]); end
    endtask

    task automatic test_late();
        bit ok;
        int n;
        press_start();
        wait_state(3'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL late_reach_test timeout state %0d want 3", state); end
        n = 0;
        while (n < 200 && state !== 3'd6) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 80) begin errors++; $display("FAIL late_cycles got %0d want 80", n); end
        checks++; if (reaction_ms !== 14'd20) begin errors++; $display("FAIL late_ms got %0d want 20", reaction_ms); end
        checks++; if (led !== 1'b0 || winner !== 3'd0) begin errors++; $display("FAIL late_led_winner led %0b win %0d want 0 0", led, winner); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        nb_cnt = 0;
        press_start();
        wait_state(3'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_reach_test timeout state %0d want 3", state); end
        wait_ms(14'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_reach_ms timeout ms %0d want 3", reaction_ms); end
        stop_b = 2'b11;
        wait_state(3'd5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_reach_good timeout state %0d want 5", state); end
        repeat (3) @(negedge clk);
        stop_b = 2'b00;
        checks++; if (winner !== 3'd0 || reaction_ms !== 14'd3) begin errors++; $display("FAIL simul_result win %0d ms %0d want 0 3", winner, reaction_ms); end
        checks++; if (best_ms !== {14'd7, 14'd3} || nb_cnt !== 1) begin
            errors++; $display("FAIL simul_best slots %0d,%0d pulses %0d want 3,7 1", best_ms[TW-1:0], best_ms[2*TW-1:TW], nb_cnt); end
    endtask

    task automatic test_clear_beats_start();
        @(negedge clk);
        start_b = 1'b1;
        clear_b = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL clear_state got %0d want 0", state); end
        checks++; if (reaction_ms !== 0 || winner !== 0 || led !== 1'b0) begin
            errors++; $display("FAIL clear_outs ms %0d win %0d led %0b want 0 0 0", reaction_ms, winner, led); end
        checks++; if (best_ms !== {14'd7, 14'd3}) begin errors++; $display("FAIL clear_slots got %0d,%0d want 3,7", best_ms[TW-1:0], best_ms[2*TW-1:TW]); end
        start_b = 1'b0;
        clear_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        press_start();
        wait_state(3'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_reach_test timeout state %0d want 3", state); end
        wait_ms(14'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_reach_ms timeout ms %0d want 2", reaction_ms); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || led !== 1'b0) begin errors++; $display("FAIL arst_state_led state %0d led %0b want 0 0", state, led); end
        checks++; if (reaction_ms !== 0 || winner !== 0 || new_best !== 1'b0) begin
            errors++; $display("FAIL arst_outs ms %0d win %0d nb %0b want 0 0 0", reaction_ms, winner, new_best); end
        checks++; if (best_ms !== {C_ALL1, C_ALL1}) begin errors++; $display("FAIL arst_slots got %0d,%0d want 16383,16383", best_ms[TW-1:0], best_ms[2*TW-1:TW]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_good_round();
        test_back_to_back();
        test_early();
        test_late();
        test_simultaneous();
        test_clear_beats_start();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
